// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: ALU opcodes,
// MDU operation codes and sequencer state encoding.
package mdu_seq_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [7:0] ALUOP_ADD = 8'd0;
  localparam logic [7:0] ALUOP_SUB = 8'd1;

  localparam logic [1:0] MDU_MULTU = 2'd0;
  localparam logic [1:0] MDU_DIVU  = 2'd1;
  localparam logic [1:0] MDU_MTHI  = 2'd2;
  localparam logic [1:0] MDU_MTLO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq_alu.sv
// 32-bit combinational add/sub ALU shared with the main datapath encoding.
module mdu_seq_alu
  import mdu_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [7:0]  alu_op,
  output logic [31:0] res
);

  always_comb begin
    res = a + b;
    if (alu_op == ALUOP_SUB) res = a - b;
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative unsigned MULTU/DIVU sequencer owning architectural HI/LO,
// plus single-cycle MTHI/MTLO writes.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; MTHI/MTLO write here in one cycle
// MUL     | shift-add multiply, one multiplier bit per cycle
// DIV     | restoring divide, one quotient bit per cycle
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  mdu_state_t  state;
  logic [31:0] mcand, acc, mlo;
  logic [31:0] dvsr, quo;
  logic [32:0] rem;
  logic [4:0]  cnt;

  logic [31:0] alu_a, alu_b, alu_res;
  logic [7:0]  alu_op;
  logic        mul_carry, div_ok;
  logic [32:0] div_t;
  logic [31:0] acc_next, mlo_next, quo_next;
  logic [32:0] rem_next;

  mdu_seq_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .res    (alu_res)
  );

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALUOP_ADD;
    div_t  = {rem[31:0], quo[31]};
    case (state)
      ST_MUL: begin
        alu_a = acc;
        alu_b = mlo[0] ? mcand : 32'd0;
      end
      ST_DIV: begin
        alu_a  = div_t[31:0];
        alu_b  = dvsr;
        alu_op = ALUOP_SUB;
      end
      default: ;
    endcase
    // A wrapped sum is smaller than either addend, which exposes the carry.
    mul_carry = alu_res < acc;
    acc_next  = {mul_carry, alu_res[31:1]};
    mlo_next  = {alu_res[0], mlo[31:1]};
    div_ok    = div_t[32] | (div_t[31:0] >= dvsr);
    rem_next  = div_ok ? {1'b0, alu_res} : div_t;
    quo_next  = {quo[30:0], div_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      acc   <= '0;
      mlo   <= '0;
      dvsr  <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MDU_MTHI: hi <= rs_val;
              MDU_MTLO: lo <= rs_val;
              MDU_MULTU: begin
                mcand <= rs_val;
                acc   <= '0;
                mlo   <= rt_val;
                cnt   <= '0;
                state <= ST_MUL;
                busy  <= 1'b1;
              end
              default: begin
                dvsr  <= rt_val;
                rem   <= '0;
                quo   <= rs_val;
                cnt   <= '0;
                state <= ST_DIV;
                busy  <= 1'b1;
              end
            endcase
          end
        end
        ST_MUL: begin
          acc <= acc_next;
          mlo <= mlo_next;
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) begin
            hi    <= acc_next;
            lo    <= mlo_next;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) begin
            hi    <= rem_next[31:0];
            lo    <= quo_next;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: arithmetic reference model feeds a queue,
// a negedge monitor checks HI/LO hold during busy and results when busy falls.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  localparam int N_ITER = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu_seq #(.ITER(N_ITER)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] hold_hi = '0, hold_lo = '0;
  int          m_busy_left = 0;
  logic        rst_q = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) rst_q <= reset;

  // Monitor: architectural HI/LO must not move while busy; results appear when busy drops.
  int   busy_cnt = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_cnt++;
      check("hold_hi", hi, hold_hi);
      check("hold_lo", lo, hold_lo);
    end else if (busy_prev) begin
      if (rst_q) begin
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
      end else if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("busy_cycles", 32'(busy_cnt), 32'(N_ITER));
      end
      busy_cnt = 0;
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic cycle();
    @(negedge clk);
    if (m_busy_left > 0) m_busy_left--;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic        accepted;
    logic [63:0] prod;
    exp_t        e;
    accepted = (m_busy_left == 0);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (accepted) begin
      case (o)
        MDU_MTHI: m_hi = a;
        MDU_MTLO: m_lo = a;
        MDU_MULTU: begin
          prod = 64'(a) * 64'(b);
          hold_hi = m_hi; hold_lo = m_lo;
          m_hi = prod[63:32]; m_lo = prod[31:0];
          m_busy_left = N_ITER + 1;
        end
        default: begin
          hold_hi = m_hi; hold_lo = m_lo;
          if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
          else begin m_lo = a / b; m_hi = a % b; end
          m_busy_left = N_ITER + 1;
        end
      endcase
      if (o == MDU_MULTU || o == MDU_DIVU) begin
        e.hi = m_hi; e.lo = m_lo;
        sb_q.push_back(e);
      end
    end
    cycle();
    start = 1'b0;
    if (accepted && (o == MDU_MTHI || o == MDU_MTLO)) begin
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
      check("mt_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_idle();
    while (m_busy_left > 0) cycle();
    check("idle_after_op", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    issue(MDU_MTHI, 32'hAAAA, 32'h0);
    issue(MDU_MTLO, 32'h5555, 32'h0);

    issue(MDU_MULTU, 32'd3, 32'd5);
    repeat (5) cycle();
    issue(MDU_MTHI, 32'h9, 32'h0);
    wait_idle();
    check("mul_3x5_lo", lo, 32'd15);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_idle();
    issue(MDU_DIVU, 32'h8000_0000, 32'h8000_0001);
    wait_idle();
    issue(MDU_DIVU, 32'h1234, 32'd0);
    wait_idle();

    issue(MDU_MTHI, 32'h11, 32'h0);
    issue(MDU_MTLO, 32'h22, 32'h0);
    issue(MDU_MULTU, 32'h1_0000, 32'h1_0000);
    wait_idle();
    // back-to-back: issued at the first negedge with busy low
    issue(MDU_DIVU, 32'hDEAD_BEEF, 32'd13);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = 32'd0;
        default: rb = ra >> $urandom_range(0, 31);
      endcase
      issue(ro, ra, rb);
      if (ro == MDU_MULTU || ro == MDU_DIVU) wait_idle();
    end

    // abort a divide at busy cycle 10
    issue(MDU_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (9) cycle();
    reset = 1'b1;
    sb_q.delete();
    m_hi = '0; m_lo = '0; m_busy_left = 0;
    cycle();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi_now", hi, 32'd0);
    check("abort_lo_now", lo, 32'd0);
    issue(MDU_MULTU, 32'd2, 32'd3);
    wait_idle();
    check("mul_2x3_lo", lo, 32'd6);

    repeat (3) cycle();
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Unsigned multiply/divide sequencer for the CPU's HI/LO unit. Executes MULTU and DIVU as 32-cycle iterative loops over one instance of the team's 32-bit ALU (add/sub).
- Sits beside the main datapath. Decode drives `start` and `op`. `busy` stalls later HI/LO users. `hi`/`lo` feed MFHI/MFLO.
- Also services MTHI/MTLO as single-cycle register writes.

Parameters:
- ITER, 32, iterations per multiply/divide. Must equal the operand width; fixed at 32.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch or execute `op` this cycle
- op  in  2  0=MULTU, 1=DIVU, 2=MTHI, 3=MTLO
- rs_val  in  32  multiplicand / dividend / MTHI-MTLO data
- rt_val  in  32  multiplier / divisor (ignored for MTHI/MTLO)
- busy  out  1  iterative operation in progress
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`. At a reset edge: state=IDLE, busy=0, hi=0, lo=0, and all working registers = 0.
- Reset mid-operation aborts the operation. hi/lo are cleared to 0, not loaded with partial results.
- Internal ALU: combinational, ports A, B, ALUOp[7:0], res. ALUOp encoding: 0=add, 1=sub. `is_eq` is unused.
- States: IDLE, MUL, DIV.
- IDLE with start=1:
  - op=2: hi<=rs_val at this edge.
  - op=3: lo<=rs_val at this edge.
  - op=0: load mcand=rs_val, acc=0, mlo=rt_val, cnt=0; go to MUL.
  - op=1: load dvsr=rt_val, rem=0 (33-bit), quo=rs_val, cnt=0; go to DIV.
- `busy` is a registered output, equal to (state != IDLE). It rises the cycle after the start edge and stays high for exactly 32 cycles.
- MUL step, one per cycle:
  - ALU A=acc, B=(mlo[0] ? mcand : 0), ALUOp=0.
  - carry = (res < acc), unsigned compare.
  - {acc, mlo} <= {carry, res, mlo} >> 1.
- DIV step, one per cycle:
  - Form t = {rem[31:0], quo[31]} (33 bits).
  - ALU A=t[31:0], B=dvsr, ALUOp=1.
  - ok = t[32] | (t[31:0] >= dvsr).
  - If ok: rem <= {1'b0, res}, quo <= {quo[30:0], 1}. Otherwise: rem <= t, quo <= {quo[30:0], 0}.
- In IDLE the ALU is driven with A=0, B=0, ALUOp=0. The output is unused.
- cnt increments each step. On the step where cnt==ITER-1:
  - MUL: hi<=acc_next, lo<=mlo_next.
  - DIV: hi<=rem_next[31:0], lo<=quo_next.
  - Return to IDLE; busy falls after that edge.
  - Result visible in the first cycle busy==0.
- hi/lo hold their previous values throughout busy. Intermediate values are never visible.
- start while busy is ignored entirely, including MTHI/MTLO. Decode must stall on busy.
- Divide by zero: no special path, same 32-cycle latency. Result is lo=0xFFFFFFFF, hi=rs_val.
- Back-to-back: start in the first cycle after busy falls is accepted.

Decomposition:
- Shared package holds:
  - ALUOP_ADD=0 and ALUOP_SUB=1 (8-bit), shared with the main datapath decode.
  - MDU op codes MDU_MULTU=0, MDU_DIVU=1, MDU_MTHI=2, MDU_MTLO=3.
  - State encoding.
- One sub-module: an instance of the existing ALU module. Counter, shift registers and FSM stay in mdu_seq.

Test Plan:
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high 32 cycles; afterwards hi=0xFFFFFFFE, lo=0x00000001. This exercises the carry path.
- DIVU: rs=100, rt=7 -> after 32 busy cycles lo=14, hi=2. DIVU rs=0x80000000, rt=0x80000001 -> lo=0, hi=0x80000000.
- DIVU by zero: rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, 32-cycle latency.
- MTHI 0xAAAA then MTLO 0x5555 on consecutive cycles -> hi=0xAAAA, lo=0x5555 one cycle each; busy stays 0. Start MULTU 3*5, then assert MTHI 0x9 during busy -> ignored; final hi=0, lo=15.
- Prior hi/lo=0x11/0x22, start MULTU 0x10000*0x10000 -> hi/lo read 0x11/0x22 every busy cycle; then hi=1, lo=0.
- Assert reset at busy cycle 10 of a DIVU -> next cycle busy=0, hi=0, lo=0. A new MULTU 2*3 then completes with lo=6.
